// File: rtl/tx_serial_core.sv
// tx_serial_core: byte FIFO feeding an async serial framer (start, LSB-first data, optional parity, 1/2 stop)
module tx_serial_core #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          enable,
  input  logic                          parity_en,
  input  logic                          parity_odd,
  input  logic                          stop2,
  input  logic [CNT_W-1:0]              baud_div,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          wr_en,
  input  logic                          clr_ovf,
  output logic                          tx_out,
  output logic                          busy,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          frame_done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state_q, state_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0] head, shift_q, shift_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, div_q, div_d;
  logic [3:0] idx_q, idx_d;
  logic ovf_q, ovf_d, par_q, par_d, par_en_q, par_en_d, stop2_q, stop2_d;
  logic tick, last_stop, pop, push;
  assign head       = mem_q[rd_ptr_q];
  assign fifo_empty = count_q == '0;
  assign fifo_full  = count_q == CW'(FIFO_DEPTH);
  assign fifo_count = count_q;
  assign overflow   = ovf_q;
  assign busy       = state_q != IDLE;
  assign tick       = cnt_q == '0;
  assign last_stop  = state_q == STOP && tick && idx_q == {3'b000, stop2_q};
  assign frame_done = last_stop;
  // a pop may only happen from IDLE or in the final stop cycle, so it never meets an empty-FIFO write
  assign pop        = enable && !fifo_empty && (state_q == IDLE || last_stop);
  assign push       = wr_en && (!fifo_full || pop);
  assign tx_out     = state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : state_q == PARITY ? par_q : 1'b1;
  // FIFO bookkeeping, sticky overflow, and the frame sequencer
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    ovf_d    = (ovf_q && !clr_ovf) || (wr_en && !push);
    state_d  = state_q;
    cnt_d    = tick ? div_q : cnt_q - 1'b1;
    div_d    = div_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    par_d    = par_q;
    par_en_d = par_en_q;
    stop2_d  = stop2_q;
    if (pop) begin
      shift_d  = head;
      par_d    = ^head ^ parity_odd;
      par_en_d = parity_en;
      stop2_d  = stop2;
      div_d    = baud_div;
      cnt_d    = baud_div;
      idx_d    = '0;
      state_d  = START;
    end else if (tick) begin
      case (state_q)
        START:  state_d = DATA;
        DATA: begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q == LAST_BIT ? '0 : idx_q + 1'b1;
          state_d = idx_q != LAST_BIT ? DATA : par_en_q ? PARITY : STOP;
        end
        PARITY: state_d = STOP;
        STOP: begin
          idx_d   = idx_q + 1'b1;
          state_d = last_stop ? IDLE : STOP;
        end
        default: state_d = state_q;
      endcase
    end
  end
  // FIFO storage; contents need no reset since occupancy gates every read
  always_ff @(posedge ACLK) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end
  // state registers with synchronous active-low reset
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      div_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
      stop2_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      par_en_q <= par_en_d;
      stop2_q  <= stop2_d;
    end
  end
endmodule

// File: tb/tb_tx_serial_core.sv
// tb_tx_serial_core: frame table, corner-case sequences and random traffic against a waveform-queue model
module tb_tx_serial_core;
  localparam int DB = 8;
  localparam int DEPTH = 4;
  localparam int CNTW = 16;
  logic ACLK = 1'b0, ARESETN = 1'b0, enable = 1'b0, parity_en = 1'b0, parity_odd = 1'b0;
  logic stop2 = 1'b0, wr_en = 1'b0, clr_ovf = 1'b0;
  logic [CNTW-1:0] baud_div = 16'd3;
  logic [DB-1:0] wr_data = '0;
  logic tx_out, busy, fifo_full, fifo_empty, overflow, frame_done;
  logic [2:0] fifo_count;
  int n_vec = 0, n_bad = 0;
  always #5 ACLK = ~ACLK;
  tx_serial_core #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH), .CNT_W(CNTW)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .enable(enable), .parity_en(parity_en),
    .parity_odd(parity_odd), .stop2(stop2), .baud_div(baud_div), .wr_data(wr_data),
    .wr_en(wr_en), .clr_ovf(clr_ovf), .tx_out(tx_out), .busy(busy), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .fifo_count(fifo_count), .overflow(overflow), .frame_done(frame_done)
  );
  typedef struct {bit tx; bit done;} samp_t;
  samp_t wave[$];
  logic [DB-1:0] fq[$];
  bit m_ovf = 1'b0;
  task automatic chk(string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask
  task automatic build_frame(input logic [DB-1:0] d);
    bit b[$];
    samp_t s;
    b.push_back(1'b0);
    for (int i = 0; i < DB; i++) b.push_back(d[i]);
    if (parity_en) b.push_back(^d ^ parity_odd);
    b.push_back(1'b1);
    if (stop2) b.push_back(1'b1);
    foreach (b[i]) for (int k = 0; k <= int'(baud_div); k++) begin
      s.tx = b[i];
      s.done = 1'b0;
      wave.push_back(s);
    end
    s = wave.pop_back();
    s.done = 1'b1;
    wave.push_back(s);
  endtask
  task automatic step();
    logic [8:0] e_v, a_v;
    bit pop, full;
    @(posedge ACLK);
    if (!ARESETN) begin
      fq.delete();
      wave.delete();
      m_ovf = 1'b0;
    end else begin
      pop = enable && fq.size() > 0 && wave.size() <= 1;
      full = fq.size() == DEPTH;
      m_ovf = (m_ovf && !clr_ovf) || (wr_en && full && !pop);
      if (wave.size() > 0) void'(wave.pop_front());
      if (pop) build_frame(fq.pop_front());
      if (wr_en && (!full || pop)) fq.push_back(wr_data);
    end
    #1;
    e_v = {wave.size() > 0 ? wave[0].tx : 1'b1, wave.size() > 0, wave.size() > 0 ? wave[0].done : 1'b0,
           fq.size() == DEPTH, fq.size() == 0, m_ovf, 3'(fq.size())};
    a_v = {tx_out, busy, frame_done, fifo_full, fifo_empty, overflow, fifo_count};
    n_vec++;
    if (a_v !== e_v) begin
      n_bad++;
      $display("FAIL model {tx,busy,done,full,empty,ovf,count}: got %b expected %b at %0t", a_v, e_v, $time);
    end
  endtask
  task automatic write_byte(input logic [DB-1:0] d);
    wr_data = d;
    wr_en = 1'b1;
    step();
    wr_en = 1'b0;
  endtask
  task automatic wait_not_busy();
    int k = 0;
    while (busy && k < 2000) begin
      step();
      k++;
    end
    chk("busy_timeout", k < 2000, 1);
  endtask
  typedef struct {int div; bit pe; bit po; bit s2; logic [7:0] d; int len; logic [11:0] bits;} fvec_t;
  fvec_t tv[5];
  initial begin
    int len, dn, badb, c, first_done;
    tv[0] = '{3, 1'b0, 1'b0, 1'b0, 8'h55, 40, 12'h2AA};
    tv[1] = '{3, 1'b1, 1'b0, 1'b1, 8'h07, 48, 12'hE0E};
    tv[2] = '{0, 1'b1, 1'b1, 1'b0, 8'hA5, 11, 12'h74A};
    tv[3] = '{1, 1'b0, 1'b0, 1'b1, 8'h80, 22, 12'h700};
    tv[4] = '{2, 1'b1, 1'b0, 1'b0, 8'h00, 33, 12'h400};
    step();
    step();
    chk("rst_tx", tx_out, 1);
    chk("rst_busy", busy, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_done", frame_done, 0);
    ARESETN = 1'b1;
    enable = 1'b1;
    step();
    foreach (tv[t]) begin
      baud_div = 16'(tv[t].div);
      parity_en = tv[t].pe;
      parity_odd = tv[t].po;
      stop2 = tv[t].s2;
      write_byte(tv[t].d);
      chk("lat_idle", busy, 0);
      step();
      chk("lat_start", {busy, tx_out}, 2'b10);
      len = 0;
      dn = 0;
      badb = 0;
      while (busy && len < 500) begin
        if (tx_out !== tv[t].bits[len / (tv[t].div + 1)]) badb++;
        dn += int'(frame_done);
        len++;
        step();
      end
      chk("frame_len", len, tv[t].len);
      chk("frame_bits", badb, 0);
      chk("frame_done_cnt", dn, 1);
      step();
    end
    enable = 1'b0;
    baud_div = 16'd3;
    parity_en = 1'b0;
    stop2 = 1'b0;
    for (int i = 1; i <= 5; i++) write_byte(8'(i));
    chk("ovf_count", fifo_count, 4);
    chk("ovf_full", fifo_full, 1);
    chk("ovf_flag", overflow, 1);
    enable = 1'b1;
    step();
    c = 0;
    dn = 0;
    while (busy && c < 1000) begin
      c++;
      dn += int'(frame_done);
      step();
    end
    chk("b2b_len", c, 160);
    chk("b2b_done", dn, 4);
    chk("b2b_empty", fifo_empty, 1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("clr_ovf", overflow, 0);
    write_byte(8'hC3);
    write_byte(8'h3C);
    c = 0;
    first_done = -1;
    while (busy && c < 1000) begin
      if (frame_done && first_done < 0) first_done = c + 1;
      if (c == 5) baud_div = 16'd7;
      c++;
      step();
    end
    chk("baud_f1", first_done, 40);
    chk("baud_f2", c - first_done, 80);
    baud_div = 16'd3;
    step();
    write_byte(8'h5A);
    repeat (12) step();
    write_byte(8'hA5);
    enable = 1'b0;
    wait_not_busy();
    chk("en_hold_count", fifo_count, 1);
    repeat (3) step();
    chk("en_hold_busy", busy, 0);
    enable = 1'b1;
    step();
    chk("en_resume_busy", busy, 1);
    chk("en_resume_count", fifo_count, 0);
    wait_not_busy();
    write_byte(8'h11);
    write_byte(8'h22);
    repeat (10) step();
    ARESETN = 1'b0;
    step();
    chk("mid_rst_tx", tx_out, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_count", fifo_count, 0);
    ARESETN = 1'b1;
    c = 0;
    repeat (50) begin
      step();
      c += int'(busy);
    end
    chk("post_rst_quiet", c, 0);
    repeat (3000) begin
      ARESETN = $urandom_range(0, 199) != 0;
      enable = $urandom_range(0, 9) != 0;
      wr_en = $urandom_range(0, 3) == 0;
      wr_data = 8'($urandom);
      parity_en = 1'($urandom);
      parity_odd = 1'($urandom);
      stop2 = 1'($urandom);
      baud_div = 16'($urandom_range(0, 3));
      clr_ovf = $urandom_range(0, 19) == 0;
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/tx_serial_core.md
Name: tx_serial_core

Overview:
Serial transmit engine fed by the Transmitter AXI4-Lite register bank. It buffers bytes written through the data register in a small FIFO and serialises each byte as an asynchronous frame: start bit, data LSB-first, optional parity, then 1 or 2 stop bits. Status outputs are routed back to the register bank's read-only status register.

Parameters:
DATA_BITS, 8, payload bits per frame (5..8)
FIFO_DEPTH, 4, byte FIFO entries (power of 2, >=2)
CNT_W, 16, width of baud divisor

Ports:
ACLK  in  1  system clock
ARESETN  in  1  synchronous active-low reset
enable  in  1  control-register bit; 0 holds the FSM in IDLE after the current frame
parity_en  in  1  1 = append a parity bit
parity_odd  in  1  1 = odd parity, 0 = even parity
stop2  in  1  1 = two stop bits
baud_div  in  CNT_W  bit period minus 1, in ACLK cycles
wr_data  in  DATA_BITS  byte to enqueue
wr_en  in  1  one-cycle write strobe from the data-register write
clr_ovf  in  1  clears the sticky overflow flag
tx_out  out  1  serial line, idle high
busy  out  1  frame in progress
fifo_full  out  1  FIFO full
fifo_empty  out  1  FIFO empty
fifo_count  out  clog2(FIFO_DEPTH)+1  occupancy
overflow  out  1  sticky: write attempted while full
frame_done  out  1  one-cycle pulse at the end of the last stop bit

Behaviour:
- Reset values (ARESETN=0 sampled on the ACLK edge): tx_out=1, busy=0, fifo_empty=1, fifo_full=0, fifo_count=0, overflow=0, frame_done=0. FSM=IDLE, pointers=0.
- A reset asserted mid-frame aborts the frame. tx_out returns high on the next edge and FIFO contents are discarded.
- FIFO write: wr_en && !fifo_full enqueues wr_data. wr_en && fifo_full drops the data and sets overflow.
- Simultaneous write and pop with the FIFO full is not a full-write: the pop happens on the same edge, so the write is accepted and count is unchanged.
- Simultaneous write and pop with the FIFO empty cannot occur. A pop requires a non-empty FIFO, so a write to an empty FIFO is popped at the earliest on the next cycle.
- Pointers wrap modulo FIFO_DEPTH.
- overflow clears on clr_ovf. If clr_ovf coincides with a new overflow event, overflow stays set.
- Bit timer: on entering each bit, the down-counter loads the latched baud_div and the bit ends when the counter reaches 0. Each bit lasts baud_div+1 cycles.
- baud_div is latched at the START transition. Changes mid-frame affect the next frame only.
- FSM states:
  - IDLE: tx_out=1. If enable && !fifo_empty, pop the head into the shift register, compute parity and latch the config, then go to START on the next edge. busy rises with START.
  - START: tx_out=0 for one bit period, then DATA.
  - DATA: tx_out=shift[0]; shift right each bit period. After DATA_BITS bits, go to PARITY if parity_en, else STOP.
  - PARITY: tx_out = XOR(data) ^ parity_odd for one bit period, then STOP.
  - STOP: tx_out=1 for 1 or 2 bit periods per the latched stop2.
- End of STOP: frame_done pulses for one cycle. If enable && !fifo_empty, the FSM goes directly to START, popping the next byte with no idle gap (back-to-back frames). Otherwise it goes to IDLE and busy falls.
- enable deasserted mid-frame lets the current frame complete; no new frame starts.
- parity_en, parity_odd and stop2 are latched at the pop and are stable for the whole frame.
- Latency from wr_en into an empty FIFO (enable=1, IDLE) to the tx_out falling edge: 2 cycles. Cycle 1 enqueues, cycle 2 pops; START is visible after edge 2.
- Frame length in cycles = (baud_div+1) × (1 + DATA_BITS + parity_en + 1 + stop2).

Test Plan:
- Reset, then baud_div=3, no parity, 1 stop, write 0x55 -> tx_out low 2 cycles after write, then bits 1,0,1,0,1,0,1,0 each 4 cycles, stop high 4 cycles; frame 40 cycles; frame_done pulses once; busy=0 after.
- parity_en=1, parity_odd=0, stop2=1, write 0x07 -> parity bit 1, two stop bits; frame length 12×(baud_div+1).
- Write 5 bytes 0x01..0x05 back-to-back with enable=0 -> fifo_count=4, fifo_full=1, overflow=1. Set enable=1 -> bytes 0x01..0x04 sent contiguously with no idle gap and 0x05 is absent. clr_ovf=1 -> overflow=0.
- Change baud_div from 3 to 7 during frame 1 of 2 -> frame 1 uses 4-cycle bits, frame 2 uses 8-cycle bits.
- Drop enable during the DATA state -> the frame completes and the queued byte stays in the FIFO (fifo_count=1). Re-enable -> it is sent.
- Assert ARESETN=0 mid-DATA -> next edge: tx_out=1, busy=0, fifo_count=0. After release, no frame emitted.
